// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-bus request/response signals between the fetch controller and memory.
// The master issues one address request; the slave acknowledges it, then returns data.
interface pc_fetch_ctrl_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: one outstanding instruction-bus read, with delay-slot branches and exception redirect.
// Latency is bus-dependent (REQ->WAIT->HOLD); StallF holds the fetched word in HOLD with no new request.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   StallF,
   input  logic                   PCSrcD,
   input  logic [31:0]            PCBranchD,
   input  logic                   ExcFlush,
   input  logic [31:0]            ExcPC,
   pc_fetch_ctrl_if.master        instBus,
   output logic [31:0]            PCF,
   output logic [31:0]            InstrF,
   output logic                   InstrValidF
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state;
   state_t      stateNext;
   logic [31:0] pcNext;
   logic [31:0] instrNext;
   logic        discard;
   logic        discardNext;
   logic        brPend;
   logic        brPendNext;
   logic [31:0] brTgt;
   logic [31:0] brTgtNext;

   assign instBus.inst_req  = (state == REQ);
   assign instBus.inst_addr = PCF;
   assign InstrValidF       = (state == HOLD);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         PCF     <= RESET_PC;
         InstrF  <= 32'd0;
         discard <= 1'b0;
         brPend  <= 1'b0;
         brTgt   <= 32'd0;
      end else begin
         state   <= stateNext;
         PCF     <= pcNext;
         InstrF  <= instrNext;
         discard <= discardNext;
         brPend  <= brPendNext;
         brTgt   <= brTgtNext;
      end
   end

   always_comb begin
      stateNext   = state;
      pcNext      = PCF;
      instrNext   = InstrF;
      discardNext = discard;
      brPendNext  = brPend;
      brTgtNext   = brTgt;

      // A branch resolved in decode is remembered until its delay slot is consumed.
      if (PCSrcD) begin
         brPendNext = 1'b1;
         brTgtNext  = PCBranchD;
      end

      case (state)
         IDLE: stateNext = REQ;
         REQ: begin
            if (instBus.inst_addr_ok) stateNext = WAIT;
         end
         WAIT: begin
            if (instBus.inst_data_ok) begin
               if (discard) begin
                  discardNext = 1'b0;
                  stateNext   = REQ;
               end else begin
                  instrNext = instBus.inst_rdata;
                  stateNext = HOLD;
               end
            end
         end
         HOLD: begin
            if (!StallF) begin
               stateNext  = REQ;
               brPendNext = 1'b0;
               if (PCSrcD)      pcNext = PCBranchD;
               else if (brPend) pcNext = brTgt;
               else             pcNext = PCF + 32'd4;
            end
         end
         default: stateNext = IDLE;
      endcase

      // Redirect wins over everything; an in-flight response is marked for dropping.
      if (ExcFlush) begin
         pcNext     = ExcPC;
         instrNext  = InstrF;
         brPendNext = 1'b0;
         brTgtNext  = brTgt;
         case (state)
            REQ: begin
               stateNext   = instBus.inst_addr_ok ? WAIT : REQ;
               discardNext = instBus.inst_addr_ok;
            end
            WAIT: begin
               stateNext   = instBus.inst_data_ok ? REQ : WAIT;
               discardNext = !instBus.inst_data_ok;
            end
            default: begin
               stateNext   = REQ;
               discardNext = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, hand sequences, then random traffic vs a PC-stream model.
module tb_pc_fetch_ctrl;
   localparam logic [31:0] RST_PC = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        StallF;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic        ExcFlush;
   logic [31:0] ExcPC;
   logic [31:0] PCF;
   logic [31:0] InstrF;
   logic        InstrValidF;

   pc_fetch_ctrl_if bus();

   pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .StallF     (StallF),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .ExcFlush   (ExcFlush),
      .ExcPC      (ExcPC),
      .instBus    (bus),
      .PCF        (PCF),
      .InstrF     (InstrF),
      .InstrValidF(InstrValidF)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        stall;
      logic        pcSrc;
      logic [31:0] brTgt;
      logic        flush;
      logic [31:0] excPc;
      logic        addrOk;
      logic        dataOk;
      logic [31:0] rdata;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expInstr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic s, input logic p, input logic [31:0] bt,
                               input logic f, input logic [31:0] ep, input logic ao,
                               input logic dk, input logic [31:0] rd, input logic rq,
                               input logic [31:0] ad, input logic vl, input logic [31:0] ins);
      vec_t v;
      v.stall = s; v.pcSrc = p; v.brTgt = bt; v.flush = f; v.excPc = ep;
      v.addrOk = ao; v.dataOk = dk; v.rdata = rd;
      v.expReq = rq; v.expAddr = ad; v.expValid = vl; v.expInstr = ins;
      return v;
   endfunction

   // Word the random responder returns for an address; odd multiplier keeps it unique per address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic p, input logic [31:0] bt, input logic f,
                        input logic [31:0] ep, input logic ao, input logic dk, input logic [31:0] rd);
      StallF = s; PCSrcD = p; PCBranchD = bt; ExcFlush = f; ExcPC = ep;
      bus.inst_addr_ok = ao; bus.inst_data_ok = dk; bus.inst_rdata = rd;
   endtask

   task automatic step(input logic s, input logic p, input logic [31:0] bt, input logic f,
                       input logic [31:0] ep, input logic ao, input logic dk, input logic [31:0] rd);
      @(negedge clk);
      drive(s, p, bt, f, ep, ao, dk, rd);
      @(posedge clk);
      #1;
   endtask

   task automatic expo(input string n, input logic rq, input logic [31:0] ad, input logic vl);
      chk({n, "_req"}, bus.inst_req, rq);
      chk({n, "_addr"}, bus.inst_addr, ad);
      chk({n, "_valid"}, InstrValidF, vl);
   endtask

   logic        mPend;
   logic [31:0] mPc;
   logic [31:0] mTgt;
   logic        out;
   logic [31:0] outAddr;
   int          dly;
   logic        flushLast;
   logic        holdReq;
   int          deliveries;

   initial begin
      logic        s, p, f, ao, dk;
      logic [31:0] bt, ep, rd;

      resetn = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      expo("reset", 1'b0, RST_PC, 1'b0);
      chk("reset_instr", InstrF, 32'd0);
      chk("reset_pcf", PCF, RST_PC);

      vecs.push_back(mk(0,0,0,0,0,0,0,0,                  1,32'hBFC00000,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0,0,                  0,32'hBFC00000,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'h24010001,       0,32'hBFC00000,1,32'h24010001));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                  1,32'hBFC00004,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0,0,                  0,32'hBFC00004,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'h8C020004,       0,32'hBFC00004,1,32'h8C020004));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(1,0,0,0,0,0,0,0,               0,32'hBFC00004,1,32'h8C020004));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                  1,32'hBFC00008,0,0));
      vecs.push_back(mk(0,1,32'hBFC00100,0,0,1,0,0,       0,32'hBFC00008,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'hAAAA0008,       0,32'hBFC00008,1,32'hAAAA0008));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                  1,32'hBFC00100,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0,0,                  0,32'hBFC00100,0,0));
      vecs.push_back(mk(0,1,32'hBFC00200,0,0,0,0,0,       0,32'hBFC00100,0,0));
      vecs.push_back(mk(0,0,0,1,32'hBFC00380,0,0,0,       0,32'hBFC00380,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'hDEADBEEF,       1,32'hBFC00380,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0,0,                  0,32'hBFC00380,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'h11112222,       0,32'hBFC00380,1,32'h11112222));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                  1,32'hBFC00384,0,0));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(0,0,0,0,0,0,0,0,               1,32'hBFC00384,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0,0,                  0,32'hBFC00384,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                  0,32'hBFC00384,0,0));

      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].stall, vecs[i].pcSrc, vecs[i].brTgt, vecs[i].flush, vecs[i].excPc,
              vecs[i].addrOk, vecs[i].dataOk, vecs[i].rdata);
         expo($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr, vecs[i].expValid);
         chk($sformatf("vec%0d_pcf", i), PCF, vecs[i].expAddr);
         if (vecs[i].expValid) chk($sformatf("vec%0d_instr", i), InstrF, vecs[i].expInstr);
      end

      // Reset while a read is outstanding; its late response must be ignored.
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      resetn = 1'b0;
      #1;
      expo("rst_wait", 1'b0, RST_PC, 1'b0);
      chk("rst_wait_instr", InstrF, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
      @(posedge clk);
      #1;
      expo("rst_rel", 1'b1, RST_PC, 1'b0);
      step(0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD1);
      expo("rst_late", 1'b1, RST_PC, 1'b0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 32'h3C1DBFC0);
      expo("rst_first", 1'b0, RST_PC, 1'b1);
      chk("rst_first_instr", InstrF, 32'h3C1DBFC0);

      // Flush from HOLD to the top word, wrap to zero, then a branch resolved at consumption.
      step(1, 0, 0, 1, 32'hFFFFFFFC, 0, 0, 0);
      expo("hold_flush", 1'b1, 32'hFFFFFFFC, 1'b0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 32'h00000001);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      expo("wrap", 1'b1, 32'h00000000, 1'b0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 32'h00000002);
      step(0, 1, 32'hBFC00040, 0, 0, 0, 0, 0);
      expo("br_at_consume", 1'b1, 32'hBFC00040, 1'b0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 32'h00000003);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      expo("br_not_pending", 1'b1, 32'hBFC00044, 1'b0);

      // Flush coincident with address acceptance: the response is dropped.
      step(0, 0, 0, 1, 32'hBFC00500, 1, 0, 0);
      expo("req_flush_ack", 1'b0, 32'hBFC00500, 1'b0);
      step(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
      expo("req_flush_drop", 1'b1, 32'hBFC00500, 1'b0);

      // Random traffic against a program-order PC model and a latency-randomised responder.
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      mPc = RST_PC; mPend = 1'b0; mTgt = 32'd0;
      out = 1'b0; outAddr = 32'd0; dly = 0;
      flushLast = 1'b0; holdReq = 1'b0; deliveries = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         chk("rnd_addr", bus.inst_addr, mPc);
         if (InstrValidF) chk("rnd_instr", InstrF, mem(PCF));
         if (flushLast) chk("rnd_valid_after_flush", InstrValidF, 1'b0);
         if (holdReq) chk("rnd_req_held", bus.inst_req, 1'b1);
         if (bus.inst_req) chk("rnd_one_outstanding", out, 1'b0);

         s  = ($urandom % 10) < 3;
         p  = ($urandom % 10) == 0;
         bt = $urandom & 32'hFFFFFFFC;
         f  = ($urandom % 25) == 0;
         ep = $urandom & 32'hFFFFFFFC;
         dk = 1'b0;
         rd = $urandom;
         if (out) begin
            if (dly == 0) begin
               dk = 1'b1;
               rd = mem(outAddr);
               out = 1'b0;
            end else begin
               dly--;
            end
         end
         ao = 1'b0;
         if (bus.inst_req && ($urandom % 2) == 1) begin
            ao = 1'b1;
            out = 1'b1;
            outAddr = bus.inst_addr;
            dly = $urandom % 3;
         end
         drive(s, p, bt, f, ep, ao, dk, rd);

         holdReq = bus.inst_req && !ao && !f;
         flushLast = f;
         if (f) begin
            mPc = ep;
            mPend = 1'b0;
         end else if (InstrValidF && !s) begin
            deliveries++;
            mPc = p ? bt : (mPend ? mTgt : mPc + 32'd4);
            mPend = 1'b0;
         end else if (p) begin
            mPend = 1'b1;
            mTgt = bt;
         end
         @(posedge clk);
         @(negedge clk);
      end
      chk("rnd_liveness", deliveries >= 100, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
